top_level_dec: RTL and testbench
================================

TOP_LEVEL_DEC -- requirements
Module: top_level_dec

Interface
REQ-001 Parameter W, default 128, operand width of c, d_key, n and m in bits; legal range 8..128.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 start  input  1  request decryption; sampled only in IDLE.
REQ-005 c  input  W  ciphertext, captured at start acceptance.
REQ-006 d_key  input  W  private exponent, captured at start acceptance.
REQ-007 n  input  W  modulus, captured at start acceptance.
REQ-008 m  output  W  plaintext = c^d_key mod n; held until next accepted start.
REQ-009 done  output  1  one-cycle pulse when m (or err) is valid.
REQ-010 busy  output  1  high from the cycle after acceptance through the done cycle.
REQ-011 err  output  1  operand error flag, valid with done, held with m.

Function
REQ-012 States SHALL be IDLE, LOAD, SQR, MUL, FIN; the state moves only on the clock edge.
REQ-013 IDLE + start=1 -> capture c, d_key, n; go to LOAD; start in any other state is ignored.
REQ-014 LOAD (1 cycle): if n<2 or c>=n, set err=1, m=0, go to FIN; else r=1, bit index i=W-1, go to SQR.
REQ-015 SQR (exactly W cycles): r = r*r mod n via the serial modular multiplier; then go to MUL.
REQ-016 MUL (exactly W cycles): t = r*c mod n is always computed; r=t only if d_key[i]=1 (constant time).
REQ-017 After MUL: if i=0 go to FIN, else i=i-1 and go to SQR; no leading-zero skipping.
REQ-018 FIN (1 cycle): m=r (or 0 on error), done=1, busy=1; next state IDLE.
REQ-019 Valid-operand latency SHALL be exactly 2*W*W+2 cycles from the accepting edge to the done cycle; the error path SHALL take 2 cycles.
REQ-020 Modular multiply SHALL be MSB-first interleaved: acc=2*acc, subtract n if acc>=n; add multiplicand if the multiplier bit is set, subtract n if acc>=n; internal width W+1 bits, no overflow.
REQ-021 All intermediates SHALL stay < n; d_key=0 yields m=1; c=0 with d_key>0 yields m=0.
REQ-022 start held high continuously SHALL begin a new operation on the cycle after FIN returns to IDLE.
REQ-023 Input changes on c, d_key and n after acceptance SHALL NOT affect the result.

Reset
REQ-024 With reset=0 at an edge: state=IDLE; m=0, done=0, busy=0, err=0; multiplier cleared.
REQ-025 Reset mid-operation SHALL abort without a done pulse; the first start after release runs a full operation.

Structure
REQ-026 Shared package rsa_pkg SHALL hold the W default, the state encoding, and the error-condition constants shared with top_level_enc.
REQ-027 Sub-module mod_mult_serial (W-cycle interleaved multiplier, start/done, a, b, n -> p) SHALL be instantiated once and reused for SQR and MUL.
REQ-028 No multi-bit combinational multiplier SHALL be inferred; the datapath is shift/add/compare only.

Verification
REQ-029 W=16, n=2773, d_key=157, c=948 -> m=920, err=0, done exactly 514 cycles after acceptance.
REQ-030 W=16, n=2773, d_key=17, c=920 -> m=948; round trip with top_level_enc (e=17) recovers the message.
REQ-031 W=16, n=2773, c=2773 -> err=1, m=0, done 2 cycles after acceptance; n=1 -> err=1.
REQ-032 W=16, d_key=0, c=5, n=2773 -> m=1; d_key=1, c=1234 -> m=1234; c=0, d_key=157 -> m=0.
REQ-033 Drive reset=0 at cycle 200 of an operation -> no done, all outputs 0; a restart with c=948 -> m=920 after 514 cycles.
REQ-034 Pulse start while busy, and change c mid-operation -> both ignored; only one done, with m=920.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation blocks: default operand width,
// controller state encoding and operand-rejection limits.
package rsa_pkg;

    localparam int W_DEFAULT = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        FIN
    } state_e;

    // Moduli below this value cannot hold a meaningful residue and are rejected.
    localparam int ERR_N_MIN = 2;

endpackage

// File: rtl/top_level_dec_if.sv
// Request/result bundle of the RSA decryptor: operands in, plaintext and status out.
interface top_level_dec_if
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
);

    logic         start;
    logic [W-1:0] c;
    logic [W-1:0] d_key;
    logic [W-1:0] n;
    logic [W-1:0] m;
    logic         done;
    logic         busy;
    logic         err;

    modport master (output start, c, d_key, n, input m, done, busy, err);
    modport slave  (input start, c, d_key, n, output m, done, busy, err);

endinterface

// File: rtl/mod_mult_serial.sv
// Interleaved MSB-first modular multiplier: p = a*b mod n in W cycles,
// one multiplier bit per cycle; the result is presented on the final cycle.
module mod_mult_serial
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] p,
    output logic         done,
    output logic         busy
);

    localparam int IW = $clog2(W);

    logic [W-1:0]  acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          run_q, run_d;
    logic          active;
    logic [IW-1:0] idx;
    logic [W-1:0]  acc_in;

    // Both inputs of every add/double are < n, so W+1 bits never overflow.
    function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc_v,
                                             input logic [W-1:0] a_v,
                                             input logic [W-1:0] n_v,
                                             input logic         bit_v);
        logic [W:0] t;
        t = {acc_v, 1'b0};
        if (t >= {1'b0, n_v}) t = t - {1'b0, n_v};
        if (bit_v) begin
            t = t + {1'b0, a_v};
            if (t >= {1'b0, n_v}) t = t - {1'b0, n_v};
        end
        return t[W-1:0];
    endfunction

    always_comb begin
        active = start | run_q;
        idx    = start ? IW'(W - 1) : idx_q;
        acc_in = start ? '0 : acc_q;
        p      = mm_step(acc_in, a, n, b[idx]);
        done   = active && (idx == '0);
        busy   = run_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        run_d  = run_q;
        if (active) begin
            acc_d = p;
            idx_d = idx - 1'b1;
            run_d = (idx != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/top_level_dec.sv
// Constant-time RSA decryptor: m = c^d_key mod n by left-to-right square-and-multiply
// on one shared serial modular multiplier.
module top_level_dec
    import rsa_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    top_level_dec_if.slave   bus
);

    localparam int IW = $clog2(W);

    state_e        state_q, state_d;
    logic [W-1:0]  c_q, c_d, d_q, d_d, n_q, n_d, r_q, r_d, m_q, m_d;
    logic [IW-1:0] i_q, i_d;
    logic          err_q, err_d;
    logic          bad;
    logic          mm_start, mm_done, mm_busy;
    logic [W-1:0]  mm_b, mm_p;

    assign bad      = (n_q < W'(ERR_N_MIN)) || (c_q >= n_q);
    assign mm_b     = (state_q == MUL) ? c_q : r_q;
    // The multiplier idles for no cycle: it is restarted on the first cycle of each phase.
    assign mm_start = ((state_q == SQR) || (state_q == MUL)) && !mm_busy;

    mod_mult_serial #(.W(W)) u_mm (
        .clock (clock),
        .reset (reset),
        .start (mm_start),
        .a     (r_q),
        .b     (mm_b),
        .n     (n_q),
        .p     (mm_p),
        .done  (mm_done),
        .busy  (mm_busy)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = bad ? FIN : SQR;
            SQR:     if (mm_done) state_d = MUL;
            MUL:     if (mm_done) state_d = (i_q == '0) ? FIN : SQR;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_d   = c_q;
        d_d   = d_q;
        n_d   = n_q;
        r_d   = r_q;
        i_d   = i_q;
        m_d   = m_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                c_d = bus.c;
                d_d = bus.d_key;
                n_d = bus.n;
            end
            LOAD: if (bad) begin
                m_d   = '0;
                err_d = 1'b1;
            end else begin
                r_d = W'(1);
                i_d = IW'(W - 1);
            end
            SQR: if (mm_done) r_d = mm_p;
            // The product is always formed; the key bit only selects whether it is kept.
            MUL: if (mm_done) begin
                if (d_q[i_q]) r_d = mm_p;
                if (i_q == '0) begin
                    m_d   = d_q[i_q] ? mm_p : r_q;
                    err_d = 1'b0;
                end else begin
                    i_d = i_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            m_q   <= '0;
            err_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        c_q <= c_d;
        d_q <= d_d;
        n_q <= n_d;
        r_q <= r_d;
        i_q <= i_d;
    end

    assign bus.m    = m_q;
    assign bus.err  = err_q;
    assign bus.done = (state_q == FIN);
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_top_level_dec.sv
// Directed bench for top_level_dec at W=16 using the n=2773 (47*59) RSA key pair.
module tb_top_level_dec;

    localparam int TW  = 16;
    localparam int LAT = 2 * TW * TW + 2;
    localparam int LIM = 3000;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    top_level_dec_if #(.W(TW)) bus ();

    top_level_dec #(.W(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle 1 is the cycle that begins at the accepting edge.
    task automatic run_op(input logic [TW-1:0] cv, input logic [TW-1:0] dv,
                          input logic [TW-1:0] nv, output logic [TW-1:0] mv,
                          output logic ev, output int lat, output logic b1);
        @(negedge clock);
        bus.c = cv; bus.d_key = dv; bus.n = nv; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        lat = 1;
        b1  = bus.busy;
        while (!bus.done && lat < LIM) begin
            @(posedge clock); #1;
            lat++;
        end
        mv = bus.m;
        ev = bus.err;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (bus.m !== 16'd0)  begin n_fail++; $display("FAIL reset_m got %0d want 0", bus.m); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_decrypt();
        logic [TW-1:0] mv; logic ev, b1; int lat;
        run_op(16'd948, 16'd157, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd920) begin n_fail++; $display("FAIL dec_m got %0d want 920", mv); end
        n_cmp++; if (ev !== 1'b0)    begin n_fail++; $display("FAIL dec_err got %b want 0", ev); end
        n_cmp++; if (lat !== LAT)    begin n_fail++; $display("FAIL dec_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (b1 !== 1'b1)    begin n_fail++; $display("FAIL dec_busy_c1 got %b want 1", b1); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dec_done_pulse got %b want 0", bus.done); end
        n_cmp++; if (bus.m !== 16'd920) begin n_fail++; $display("FAIL dec_m_held got %0d want 920", bus.m); end
        run_op(16'd920, 16'd17, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd948) begin n_fail++; $display("FAIL enc_key_m got %0d want 948", mv); end
    endtask

    task automatic test_errors();
        logic [TW-1:0] mv; logic ev, b1; int lat;
        run_op(16'd2773, 16'd157, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (ev !== 1'b1)  begin n_fail++; $display("FAIL err_c_eq_n got %b want 1", ev); end
        n_cmp++; if (mv !== 16'd0) begin n_fail++; $display("FAIL err_c_eq_n_m got %0d want 0", mv); end
        n_cmp++; if (lat !== 2)    begin n_fail++; $display("FAIL err_latency got %0d want 2", lat); end
        run_op(16'd0, 16'd3, 16'd1, mv, ev, lat, b1);
        n_cmp++; if (ev !== 1'b1)  begin n_fail++; $display("FAIL err_n1 got %b want 1", ev); end
        n_cmp++; if (lat !== 2)    begin n_fail++; $display("FAIL err_n1_latency got %0d want 2", lat); end
        run_op(16'd2772, 16'd157, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd2772) begin n_fail++; $display("FAIL c_n_minus_1 got %0d want 2772", mv); end
        n_cmp++; if (ev !== 1'b0)     begin n_fail++; $display("FAIL c_n_minus_1_err got %b want 0", ev); end
    endtask

    task automatic test_exponents();
        logic [TW-1:0] mv; logic ev, b1; int lat;
        run_op(16'd5, 16'd0, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd1)    begin n_fail++; $display("FAIL d0 got %0d want 1", mv); end
        run_op(16'd1234, 16'd1, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd1234) begin n_fail++; $display("FAIL d1 got %0d want 1234", mv); end
        run_op(16'd0, 16'd157, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd0)    begin n_fail++; $display("FAIL c0 got %0d want 0", mv); end
        n_cmp++; if (lat !== LAT)     begin n_fail++; $display("FAIL c0_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_reset_abort();
        logic [TW-1:0] mv; logic ev, b1; int lat; int dones;
        dones = 0;
        @(negedge clock);
        bus.c = 16'd948; bus.d_key = 16'd157; bus.n = 16'd2773; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (bus.done) dones++;
            @(posedge clock); #1;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", bus.done); end
        n_cmp++; if (bus.m !== 16'd0)   begin n_fail++; $display("FAIL abort_m got %0d want 0", bus.m); end
        n_cmp++; if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL abort_err got %b want 0", bus.err); end
        reset = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clock); #1;
            if (bus.done) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", dones); end
        run_op(16'd948, 16'd157, 16'd2773, mv, ev, lat, b1);
        n_cmp++; if (mv !== 16'd920) begin n_fail++; $display("FAIL restart_m got %0d want 920", mv); end
        n_cmp++; if (lat !== LAT)    begin n_fail++; $display("FAIL restart_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_ignore_inputs();
        int dones; int lat; logic [TW-1:0] mv;
        dones = 0; lat = 0; mv = '0;
        @(negedge clock);
        bus.c = 16'd948; bus.d_key = 16'd157; bus.n = 16'd2773; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            if (bus.done) begin
                dones++;
                if (dones == 1) begin lat = cyc; mv = bus.m; end
            end
            bus.start = (cyc == 50);
            if (cyc == 50) bus.c = 16'd5;
            if (cyc == 100) begin bus.c = 16'd1; bus.d_key = 16'd3; bus.n = 16'd99; end
            @(posedge clock); #1;
        end
        n_cmp++; if (dones !== 1)    begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        n_cmp++; if (mv !== 16'd920) begin n_fail++; $display("FAIL ignore_m got %0d want 920", mv); end
        n_cmp++; if (lat !== LAT)    begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int cyc; int lat1; logic [TW-1:0] m1;
        @(negedge clock);
        bus.c = 16'd948; bus.d_key = 16'd157; bus.n = 16'd2773; bus.start = 1'b1;
        @(posedge clock); #1;
        cyc = 1;
        while (!bus.done && cyc < LIM) begin @(posedge clock); #1; cyc++; end
        lat1 = cyc; m1 = bus.m;
        bus.c = 16'd920; bus.d_key = 16'd17;
        @(posedge clock); #1; cyc++;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap got %b want 0", bus.busy); end
        while (!bus.done && cyc < 2 * LIM) begin @(posedge clock); #1; cyc++; end
        bus.start = 1'b0;
        n_cmp++; if (lat1 !== LAT)  begin n_fail++; $display("FAIL b2b_lat1 got %0d want %0d", lat1, LAT); end
        n_cmp++; if (m1 !== 16'd920) begin n_fail++; $display("FAIL b2b_m1 got %0d want 920", m1); end
        n_cmp++; if (cyc !== 2 * LAT + 1) begin n_fail++; $display("FAIL b2b_lat2 got %0d want %0d", cyc, 2 * LAT + 1); end
        n_cmp++; if (bus.m !== 16'd948) begin n_fail++; $display("FAIL b2b_m2 got %0d want 948", bus.m); end
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop got %b want 0", bus.busy); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.c = '0; bus.d_key = '0; bus.n = '0;
        test_reset();
        test_decrypt();
        test_errors();
        test_exponents();
        test_reset_abort();
        test_ignore_inputs();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
